// File: rtl/f1_start_sequencer.sv
// F1 start-light sequencer: lights up, random hold, lights out,
// then measures driver reaction time and flags jump starts.
module f1_start_sequencer #(
   parameter int                NUM_LIGHTS = 8,
   parameter int                TICK_W     = 16,
   parameter int                LFSR_W     = 7,
   parameter logic [LFSR_W-1:0] LFSR_TAPS  = 7'b1100000,
   parameter int                RT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [TICK_W-1:0]     tick_div,
   input  logic                  trigger,
   input  logic                  react,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic                  busy,
   output logic                  jump_start,
   output logic                  rt_valid,
   output logic [RT_W-1:0]       reaction_time
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LIGHT_UP,
      S_HOLD,
      S_GO,
      S_FAULT
   } state_t;

   state_t state, state_d;

   logic              trig_q;
   logic [LFSR_W-1:0] lfsr;
   logic [TICK_W-1:0] pc;
   logic [LFSR_W-1:0] hold_cnt;
   logic [RT_W-1:0]   rt_cnt;

   logic trig_edge;
   logic in_seq;
   logic tick;
   logic last_light;
   logic hold_last;
   logic enter_lu;
   logic step_light;
   logic enter_hold;
   logic hold_step;
   logic enter_go;
   logic rt_done;

   assign trig_edge  = trigger & ~trig_q;
   assign in_seq     = (state == S_LIGHT_UP) || (state == S_HOLD);
   assign tick       = in_seq && (pc == tick_div);
   assign last_light = &lights[NUM_LIGHTS-2:0];
   assign hold_last  = (hold_cnt == LFSR_W'(1));

   // react during the countdown is a jump start and beats any tick
   assign step_light = (state == S_LIGHT_UP) && tick && !react;
   assign enter_hold = step_light && last_light;
   assign hold_step  = (state == S_HOLD) && tick && !react;
   assign enter_go   = hold_step && hold_last;
   assign rt_done    = (state == S_GO) && react;
   assign enter_lu   = (state_d == S_LIGHT_UP) && (state != S_LIGHT_UP);

   assign busy       = (state == S_LIGHT_UP) || (state == S_HOLD) ||
                       (state == S_GO);
   assign jump_start = (state == S_FAULT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE: begin
            if (trig_edge) state_d = S_LIGHT_UP;
         end
         S_LIGHT_UP: begin
            if (react)           state_d = S_FAULT;
            else if (enter_hold) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (react)         state_d = S_FAULT;
            else if (enter_go) state_d = S_GO;
         end
         S_GO: begin
            if (react) state_d = S_IDLE;
         end
         S_FAULT: begin
            if (trig_edge) state_d = S_LIGHT_UP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trig_q        <= 1'b0;
         lfsr          <= LFSR_W'(1);
         pc            <= '0;
         hold_cnt      <= '0;
         rt_cnt        <= '0;
         lights        <= '0;
         rt_valid      <= 1'b0;
         reaction_time <= '0;
      end else begin
         trig_q <= trigger;
         lfsr   <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};

         if (enter_lu)    pc <= '0;
         else if (in_seq) pc <= tick ? '0 : pc + TICK_W'(1);

         if (!((state_d == S_LIGHT_UP) || (state_d == S_HOLD)))
            lights <= '0;
         else if (step_light)
            lights <= {lights[NUM_LIGHTS-2:0], 1'b1};

         if (enter_hold)     hold_cnt <= lfsr;
         else if (hold_step) hold_cnt <= hold_cnt - LFSR_W'(1);

         // saturating count so a very late press reports all-ones
         if (enter_go)
            rt_cnt <= '0;
         else if ((state == S_GO) && (rt_cnt != '1))
            rt_cnt <= rt_cnt + RT_W'(1);

         rt_valid <= rt_done;
         if (rt_done) reaction_time <= rt_cnt;
      end
   end

endmodule
